// File: rtl/inst_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: FSM state encoding and the
// 64-bit fetch-queue entry layout {pc[63:32], inst[31:0]}.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } ifu_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifu_entry_t;

  // Word-address increment; wraps 32'hFFFFFFFF -> 32'h0 naturally.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/ifu_fetch_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries with a single-cycle flush,
// full/empty flags and an occupancy count. Head entry is read combinationally.
module ifu_fetch_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  ifu_entry_t               wr_data,
  input  logic                     rd_en,
  output ifu_entry_t               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  ifu_entry_t      mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            do_rd;
  logic            do_wr;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;

  // A read on a full queue frees the slot the same cycle; flush drops the write.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd) && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          mem_reg[gi] <= '0;
        end else if (do_wr && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC register and BOOT/FETCH/HOLD control feeding a
// fetch queue. Define IFU_PERF_CNT_EN to build the transfer/redirect counters.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] InstAdd,
  input  logic [31:0] MemInstOut,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  ifu_state_t      state_reg;
  ifu_state_t      state_next;
  logic [31:0]     pc_reg;
  logic [31:0]     pc_next;
  logic            enq;
  logic            deq;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;
  logic            q_almost_full;
  ifu_entry_t      enq_entry;
  ifu_entry_t      head;

  assign InstAdd       = pc_reg;
  assign out_valid     = !q_empty;
  assign deq           = out_valid && out_ready;
  assign out_inst      = head.inst;
  assign out_pc        = head.pc;
  assign enq_entry     = '{pc: pc_reg, inst: MemInstOut};
  assign q_almost_full = (q_count == CW'(QUEUE_DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Redirect overrides everything: the queue is flushed and this cycle's fetch dropped.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    enq        = 1'b0;
    if (redirect_en) begin
      pc_next    = redirect_pc;
      state_next = FETCH;
    end else begin
      case (state_reg)
        BOOT: begin
          state_next = FETCH;
        end
        FETCH: begin
          if (!q_full || deq) begin
            enq     = 1'b1;
            pc_next = pc_incr(pc_reg);
            if (q_almost_full && !deq) state_next = HOLD;
          end else begin
            state_next = HOLD;
          end
        end
        HOLD: begin
          if (deq) state_next = FETCH;
        end
        default: begin
          state_next = BOOT;
        end
      endcase
    end
  end

  ifu_fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_en),
    .wr_en   (enq),
    .wr_data (enq_entry),
    .rd_en   (out_ready),
    .rd_data (head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg;
  logic [31:0] flush_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (deq)         fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (redirect_en) flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_flush_cnt = flush_cnt_reg;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: the expected instruction stream is the
// run of consecutive word addresses from the last reset/redirect target.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam logic [31:0] RPC  = 32'h0;
  localparam logic [31:0] RPC2 = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] inst_add, mem_inst, redirect_pc, out_inst, out_pc;
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
  logic        redirect_en, out_valid, out_ready;

  logic [31:0] inst_add2, mem_inst2, out_inst2, out_pc2, perf_fetch_cnt2, perf_flush_cnt2;
  logic        out_valid2, out_ready2;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    if (a == 32'h0) return 32'h77df000a;
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  function automatic logic [31:0] perf_exp(input int v);
`ifdef IFU_PERF_CNT_EN
    return 32'(v);
`else
    return (v == -1) ? 32'h1 : 32'h0;
`endif
  endfunction

  assign mem_inst  = inst_of(inst_add);
  assign mem_inst2 = inst_of(inst_add2);

  inst_fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .InstAdd(inst_add), .MemInstOut(mem_inst),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  inst_fetch_unit #(.RESET_PC(RPC2), .QUEUE_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .InstAdd(inst_add2), .MemInstOut(mem_inst2),
    .redirect_en(1'b0), .redirect_pc(32'h0),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_inst(out_inst2), .out_pc(out_pc2),
    .perf_fetch_cnt(perf_fetch_cnt2), .perf_flush_cnt(perf_flush_cnt2)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];

  int xfer_total = 0;
  int xfer_base  = 0;
  int redir_cnt  = 0;
  int xfer2      = 0;
  logic [31:0] exp2 = RPC2;
  int stall_run = 0;
  int stall_max = 0;

  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_redirect = 1'b0;
  logic [31:0] prev_pc = '0, prev_inst = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic start_stream(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 4096; i++) begin
      exp_t e;
      e.pc   = pc + 32'(i);
      e.inst = inst_of(pc + 32'(i));
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1: every transfer seen so far has been clocked in.
  task automatic check_perf();
    check("perf_fetch", perf_fetch_cnt, perf_exp(xfer_total - xfer_base));
    check("perf_flush", perf_flush_cnt, perf_exp(redir_cnt));
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_en = 1'b1;
    redirect_pc = pc;
    step();
    redirect_en = 1'b0;
    redir_cnt++;
    start_stream(pc);
    $display("[TB] redirect to %h", pc);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_addr", inst_add, RPC);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    check("rst_perf_flush", perf_flush_cnt, 32'h0);
    xfer_base = xfer_total;
    redir_cnt = 0;
    start_stream(RPC);
    step();
    step();
    reset = 1'b0;
    $display("[TB] reset applied");
  endtask

  // Monitor: pops the scoreboard on every transfer and checks output stability.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid    <= 1'b0;
      prev_redirect <= 1'b0;
      stall_run     <= 0;
    end else begin
      if (prev_redirect) begin
        check("valid_after_redirect", {31'b0, out_valid}, 32'h0);
      end else if (prev_valid && !prev_ready) begin
        check("hold_valid", {31'b0, out_valid}, 32'h1);
        check("hold_pc", out_pc, prev_pc);
        check("hold_inst", out_inst, prev_inst);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_underflow: got pc %h expected none", out_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("[TB] xfer pc=%h inst=%h exp_pc=%h", out_pc, out_inst, e.pc);
          check("xfer_pc", out_pc, e.pc);
          check("xfer_inst", out_inst, e.inst);
        end
        xfer_total++;
      end
      if (out_ready && !out_valid) begin
        stall_run <= stall_run + 1;
        if (stall_run + 1 > stall_max) stall_max <= stall_run + 1;
      end else begin
        stall_run <= 0;
      end
      prev_valid    <= out_valid;
      prev_ready    <= out_ready;
      prev_pc       <= out_pc;
      prev_inst     <= out_inst;
      prev_redirect <= redirect_en;
    end
  end

  // Second instance: sequential stream from 32'hFFFFFFFF, wrapping to 0.
  always @(negedge clk) begin
    if (reset) begin
      exp2  <= RPC2;
      xfer2 <= 0;
    end else if (out_valid2 && out_ready2) begin
      check("d2_pc", out_pc2, exp2);
      check("d2_inst", out_inst2, inst_of(exp2));
      exp2  <= exp2 + 32'd1;
      xfer2 <= xfer2 + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int done;
    int iters;
    logic [31:0] rpc;
    out_ready   = 1'b1;
    out_ready2  = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = '0;
    start_stream(RPC);
    #12;
    check("init_valid", {31'b0, out_valid}, 32'h0);
    check("init_addr", inst_add, RPC);
    check("init_out_inst", out_inst, 32'h0);
    check("init_perf", perf_fetch_cnt, 32'h0);
    step();
    reset = 1'b0;

    // First fetch: address 0 during BOOT and FETCH, presented one cycle later.
    @(negedge clk);
    check("c0_valid", {31'b0, out_valid}, 32'h0);
    check("c0_addr", inst_add, 32'h0);
    @(negedge clk);
    check("c1_valid", {31'b0, out_valid}, 32'h0);
    check("c1_addr", inst_add, 32'h0);
    @(negedge clk);
    check("c2_valid", {31'b0, out_valid}, 32'h1);
    check("c2_pc", out_pc, 32'h0);
    check("c2_inst", out_inst, 32'h77df000a);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("seq_pc", out_pc, 32'(i));
    end

    // Back-pressure fills a depth-2 queue and freezes the PC.
    step();
    out_ready = 1'b0;
    apply_reset();
    repeat (5) @(negedge clk);
    check("fill_addr", inst_add, 32'h2);
    check("fill_valid", {31'b0, out_valid}, 32'h1);
    check("fill_pc", out_pc, 32'h0);
    check("fill_state", 32'(dut.state_reg), 32'(HOLD));
    step();
    out_ready = 1'b1;
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      check("drain_valid", {31'b0, out_valid}, 32'h1);
      check("drain_pc", out_pc, 32'(i));
    end

    // Redirect with a full queue.
    step();
    out_ready = 1'b0;
    step();
    step();
    step();
    check("pre_redir_valid", {31'b0, out_valid}, 32'h1);
    redirect(32'h14);
    out_ready = 1'b1;
    @(negedge clk);
    check("redir_valid", {31'b0, out_valid}, 32'h0);
    check("redir_addr", inst_add, 32'h14);
    @(negedge clk);
    check("redir_pc", out_pc, 32'h14);
    step();
    check_perf();

    // Reset while the queue is full.
    out_ready = 1'b0;
    repeat (4) step();
    check_perf();
    apply_reset();

    // Exactly 10 transfers and 3 redirects.
    done  = 0;
    iters = 0;
    while ((xfer_total - xfer_base < 10 || redir_cnt < 3) && iters < 200) begin
      done      = xfer_total - xfer_base;
      out_ready = out_valid && (done < 10);
      if ((iters == 3 || iters == 7 || iters == 11) && redir_cnt < 3)
        redirect($urandom_range(0, 255));
      else
        step();
      iters++;
    end
    if (iters >= 200) begin
      tests++;
      fails++;
      $display("FAIL perf_setup_timeout: got %0d transfers expected 10", xfer_total - xfer_base);
    end
    out_ready = 1'b0;
    step();
    check("perf10_fetch", perf_fetch_cnt, perf_exp(10));
    check("perf3_flush", perf_flush_cnt, perf_exp(3));
    check_perf();

    // Randomized phase.
    for (int it = 0; it < 1500; it++) begin
      out_ready  = ($urandom % 4) != 0;
      out_ready2 = ($urandom % 3) != 0;
      if ($urandom % 32 == 0) begin
        case ($urandom % 3)
          0:       rpc = $urandom;
          1:       rpc = 32'hFFFFFFFD + 32'($urandom % 3);
          default: rpc = 32'($urandom % 64);
        endcase
        redirect(rpc);
      end else if ($urandom % 400 == 0) begin
        apply_reset();
      end else begin
        step();
      end
      if (it % 97 == 0) check_perf();
    end

    out_ready  = 1'b0;
    out_ready2 = 1'b0;
    step();
    check_perf();
    check("d2_perf_fetch", perf_fetch_cnt2, perf_exp(xfer2));
    check("d2_perf_flush", perf_flush_cnt2, 32'h0);
    check("d2_progress", {31'b0, (xfer2 >= 3)}, 32'h1);
    check("max_stall_le10", {31'b0, (stall_max <= 10)}, 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
